// File: rtl/mult_pkg.sv
// Shared constants and types for the shift-add multiplier.
//   WIDTH_DEF  : default operand width
//   CNT_W_DEF  : iteration counter width for the default operand width
//   state_t    : controller states (IDLE, RUN)
//   cnt_width(): counter width for an arbitrary operand width
package mult_pkg;

   localparam int unsigned WIDTH_DEF = 16;
   localparam int unsigned CNT_W_DEF = $clog2(WIDTH_DEF + 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   function automatic int unsigned cnt_width(input int unsigned w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/mult_iter_counter.sv
// Iteration counter for the shift-add multiplier.
//   clk    : clock
//   rst    : synchronous active-low reset
//   clear  : zero the count (wins over enable)
//   enable : advance the count by one
//   tc_c   : terminal count, high when count == WIDTH-1 and enable is high
module mult_iter_counter
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic tc_c
);

   localparam int unsigned CNT_W = cnt_width(WIDTH);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + CNT_W'(1);
      end
   end

   assign tc_c = enable && (count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential shift-add multiplier: one accumulate/shift iteration per cycle.
// The default build is unsigned; defining MULT_SIGNED_EN switches the
// datapath to radix-2 Booth for two's complement operands and product.
//   clk          : clock
//   rst          : synchronous active-low reset
//   start        : request a multiply, honoured only while idle
//   multiplicand : operand M, captured on an accepted start
//   multiplier   : operand Q, captured on an accepted start
//   product      : last completed result (2*WIDTH bits)
//   busy         : operation in progress
//   done         : one-cycle pulse when product updates
// Timing: start accepted at edge N -> busy from N, done/product after N+WIDTH+1.
module shift_add_multiplier
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy,
   output logic                 done
);

   state_t            state;
   state_t            state_nxt;

   logic [WIDTH:0]    acc;
   logic [WIDTH-1:0]  q_reg;
   logic [WIDTH-1:0]  m_reg;
   logic              last_q;     // all WIDTH iterations have been applied
`ifdef MULT_SIGNED_EN
   logic              qm1;        // Booth q[-1] bit
`endif

   logic              accept_c;
   logic              iter_c;
   logic              finish_c;
   logic              tc_c;

   logic [WIDTH:0]    m_ext;
   logic [WIDTH:0]    acc_add;
   logic [WIDTH:0]    acc_nxt;
   logic [WIDTH-1:0]  q_nxt;

   // State register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last_q) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Control decode: accept, iterate, or complete
   always_comb begin
      accept_c = 1'b0;
      iter_c   = 1'b0;
      finish_c = 1'b0;
      case (state)
         IDLE:    accept_c = start;
         RUN: begin
            iter_c   = !last_q;
            finish_c = last_q;
         end
         default: ;
      endcase
   end

   mult_iter_counter #(
      .WIDTH (WIDTH)
   ) u_iter_counter (
      .clk    (clk),
      .rst    (rst),
      .clear  (accept_c),
      .enable (iter_c),
      .tc_c   (tc_c)
   );

   // One iteration: conditional add into the carry-extended accumulator, then shift
   always_comb begin
      acc_add = acc;
`ifdef MULT_SIGNED_EN
      m_ext = {m_reg[WIDTH-1], m_reg};
      case ({q_reg[0], qm1})
         2'b01:   acc_add = acc + m_ext;
         2'b10:   acc_add = acc - m_ext;
         default: acc_add = acc;
      endcase
      acc_nxt = {acc_add[WIDTH], acc_add[WIDTH:1]};
`else
      m_ext = {1'b0, m_reg};
      if (q_reg[0]) acc_add = acc + m_ext;
      acc_nxt = {1'b0, acc_add[WIDTH:1]};
`endif
      q_nxt = {acc_add[0], q_reg[WIDTH-1:1]};
   end

   // Datapath and registered outputs
   always_ff @(posedge clk) begin
      if (!rst) begin
         acc     <= '0;
         q_reg   <= '0;
         m_reg   <= '0;
         last_q  <= 1'b0;
`ifdef MULT_SIGNED_EN
         qm1     <= 1'b0;
`endif
         product <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         busy <= (state_nxt == RUN);
         done <= finish_c;
         if (accept_c) begin
            acc    <= '0;
            q_reg  <= multiplier;
            m_reg  <= multiplicand;
            last_q <= 1'b0;
`ifdef MULT_SIGNED_EN
            qm1    <= 1'b0;
`endif
         end else if (iter_c) begin
            acc   <= acc_nxt;
            q_reg <= q_nxt;
`ifdef MULT_SIGNED_EN
            qm1   <= q_reg[0];
`endif
            if (tc_c) last_q <= 1'b1;
         end
         if (finish_c) begin
            product <= {acc[WIDTH-1:0], q_reg};
         end
      end
   end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier (WIDTH=16).
// A cycle-level reference model predicts busy/done/product every cycle from
// arithmetic products; directed operations pin results with literal values.
module tb_shift_add_multiplier;

   localparam int unsigned W  = 16;
   localparam int unsigned PW = 2 * W;
   localparam int unsigned LAT = W + 1;

   logic          clk;
   logic          rst;
   logic          start;
   logic [W-1:0]  multiplicand;
   logic [W-1:0]  multiplier;
   logic [PW-1:0] product;
   logic          busy;
   logic          done;

   int checks = 0;
   int errors = 0;

   shift_add_multiplier #(
      .WIDTH (W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .product      (product),
      .busy         (busy),
      .done         (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MULT_SIGNED_EN
      longint sa;
      longint sb;
      sa = $signed(a);
      sb = $signed(b);
      return PW'(sa * sb);
`else
      longint unsigned ua;
      longint unsigned ub;
      ua = 64'(a);
      ub = 64'(b);
      return PW'(ua * ub);
`endif
   endfunction

   // Reference model: operation occupies LAT cycles after acceptance
   bit            m_valid = 1'b0;
   bit            m_busy;
   bit            m_done;
   logic [PW-1:0] m_prod;
   logic [PW-1:0] m_pend;
   int            m_left;

   always @(posedge clk) begin
      if (!rst) begin
         m_valid = 1'b1;
         m_busy  = 1'b0;
         m_done  = 1'b0;
         m_prod  = '0;
         m_left  = 0;
      end else if (m_valid) begin
         m_done = 1'b0;
         if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
               m_busy = 1'b0;
               m_done = 1'b1;
               m_prod = m_pend;
            end
         end else if (start) begin
            m_busy = 1'b1;
            m_left = LAT;
            m_pend = ref_mul(multiplicand, multiplier);
         end
      end
   end

   // Every-cycle comparison against the model
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (m_valid) begin
            check("busy_model", 64'(busy), 64'(m_busy));
            check("done_model", 64'(done), 64'(m_done));
            check("product_model", 64'(product), 64'(m_prod));
         end
      end
   end

   // Present a start now, scramble operands after acceptance, optionally
   // re-pulse start mid-operation, and wait (bounded) for done.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit pester,
                        output logic [PW-1:0] res, output int lat);
      int cyc;
      bit seen;
      cyc  = 0;
      seen = 1'b0;
      start        = 1'b1;
      multiplicand = a;
      multiplier   = b;
      while (!seen && cyc < 40) begin
         @(posedge clk);
         #1;
         cyc++;
         start = 1'b0;
         if (cyc == 1) begin
            multiplicand = ~a;
            multiplier   = b ^ 16'h5A5A;
         end
         if (pester && (cyc == 3 || cyc == 10)) begin
            start        = 1'b1;
            multiplicand = 16'hFFFF;
            multiplier   = 16'h7FFF;
         end
         if (done) seen = 1'b1;
      end
      if (!seen) check("done_timeout", 64'(0), 64'(1));
      res = product;
      lat = cyc - 1;
   endtask

   logic [PW-1:0] res;
   int            lat;
   bit            saw_done;

   initial begin
      rst          = 1'b0;
      start        = 1'b0;
      multiplicand = '0;
      multiplier   = '0;
      repeat (3) @(negedge clk);
      check("reset_busy", 64'(busy), 64'(0));
      check("reset_done", 64'(done), 64'(0));
      check("reset_product", 64'(product), 64'(0));
      rst = 1'b1;

      @(negedge clk);
      do_op(16'h04D2, 16'h162E, 1'b0, res, lat);
      check("mul_04d2_162e", 64'(res), 64'h006A_E9BC);
      check("latency_04d2", 64'(lat), 64'(LAT));

      @(negedge clk);
      do_op(16'hFFFF, 16'hFFFF, 1'b0, res, lat);
`ifdef MULT_SIGNED_EN
      check("mul_ffff_ffff", 64'(res), 64'h0000_0001);
`else
      check("mul_ffff_ffff", 64'(res), 64'hFFFE_0001);
`endif

      @(negedge clk);
      do_op(16'h0000, 16'hABCD, 1'b0, res, lat);
      check("mul_zero", 64'(res), 64'h0000_0000);
      check("latency_zero", 64'(lat), 64'(LAT));

`ifdef MULT_SIGNED_EN
      @(negedge clk);
      do_op(16'h8000, 16'h8000, 1'b0, res, lat);
      check("mul_8000_8000", 64'(res), 64'h4000_0000);
      @(negedge clk);
      do_op(16'h8000, 16'h0001, 1'b0, res, lat);
      check("mul_8000_0001", 64'(res), 64'hFFFF_8000);
`endif

      // Starts during busy ignored, then a start in the done cycle chains
      @(negedge clk);
      do_op(16'h1234, 16'h5678, 1'b1, res, lat);
      check("mul_ignored_starts", 64'(res), 64'h0626_0060);
      check("latency_ignored", 64'(lat), 64'(LAT));
      do_op(16'h00FF, 16'h0101, 1'b0, res, lat);
      check("mul_back_to_back", 64'(res), 64'h0000_FFFF);
      check("latency_back_to_back", 64'(lat), 64'(LAT));

      // Reset at cycle 8 aborts the operation
      @(negedge clk);
      start        = 1'b1;
      multiplicand = 16'h0F0F;
      multiplier   = 16'h00F0;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      check("busy_before_abort", 64'(busy), 64'(1));
      rst   = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      rst   = 1'b1;
      start = 1'b0;
      check("abort_busy", 64'(busy), 64'(0));
      check("abort_done", 64'(done), 64'(0));
      check("abort_product", 64'(product), 64'(0));
      saw_done = 1'b0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (done || busy) saw_done = 1'b1;
      end
      check("abort_no_done", 64'(saw_done), 64'(0));

      repeat (2) @(posedge clk);
      #2;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
